// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the N-port memory arbiter: FSM states, operation kinds
// and arbitration mode selectors.
package mem_arb_types;
  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OP_READ, OP_WRITE} op_t;
  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;
endpackage

// File: rtl/mem_port_arbiter_grant.sv
// Winner selection for the memory arbiter: round-robin from a registered
// pointer, or fixed priority with port 0 highest.
module arb_grant
  import mem_arb_types::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ARB_MODE  = ARB_RR,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] active,
  input  logic                 grant_en,
  output logic                 any,
  output logic [IDX_W-1:0]     grant_idx,
  output logic [NUM_PORTS-1:0] grant_onehot
);
  localparam logic [IDX_W:0]   NP   = (IDX_W+1)'(NUM_PORTS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PORTS-1);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Walk candidates in search order; the first active one wins.
  always_comb begin
    any       = 1'b0;
    grant_idx = '0;
    sum       = '0;
    cand      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sum  = (ARB_MODE == ARB_FIXED) ? (IDX_W+1)'(i) : {1'b0, ptr} + (IDX_W+1)'(i);
      cand = IDX_W'((sum >= NP) ? sum - NP : sum);
      if (!any && active[cand]) begin
        any       = 1'b1;
        grant_idx = cand;
      end
    end
    grant_onehot            = '0;
    grant_onehot[grant_idx] = any;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (ARB_MODE == ARB_RR && grant_en && any) begin
      ptr <= (grant_idx == LAST) ? '0 : grant_idx + IDX_W'(1);
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Merges NUM_PORTS hold-until-resp request ports onto one downstream memory
// port; the granted request is latched so later requester changes are ignored.
module mem_port_arbiter
  import mem_arb_types::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ARB_MODE  = ARB_RR
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req_read,
  input  logic [NUM_PORTS-1:0]          req_write,
  input  logic [NUM_PORTS*DATA_W/8-1:0] req_wmask,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_address,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
  output logic [NUM_PORTS-1:0]          req_resp,
  output logic [DATA_W-1:0]             req_rdata,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [DATA_W/8-1:0]           mem_wmask,
  output logic [ADDR_W-1:0]             mem_address,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic                          mem_resp,
  input  logic [DATA_W-1:0]             mem_rdata
);
  localparam int MASK_W = DATA_W/8;
  localparam int IDX_W  = $clog2(NUM_PORTS);

  state_t               state;
  op_t                  g_op;
  logic [NUM_PORTS-1:0] owner_q;
  logic [NUM_PORTS-1:0] active;
  logic                 any;
  logic [IDX_W-1:0]     g_idx;
  logic [NUM_PORTS-1:0] g_onehot;

  assign active = req_read | req_write;
  // A port raising both strobes is served as a write.
  assign g_op   = req_write[g_idx] ? OP_WRITE : OP_READ;

  arb_grant #(
    .NUM_PORTS(NUM_PORTS),
    .ARB_MODE (ARB_MODE),
    .IDX_W    (IDX_W)
  ) u_grant (
    .clk         (clk),
    .rst         (rst),
    .active      (active),
    .grant_en    (state == IDLE),
    .any         (any),
    .grant_idx   (g_idx),
    .grant_onehot(g_onehot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner_q     <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_wmask   <= '0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          state       <= BUSY;
          owner_q     <= g_onehot;
          mem_read    <= (g_op == OP_READ);
          mem_write   <= (g_op == OP_WRITE);
          mem_wmask   <= req_wmask[g_idx*MASK_W +: MASK_W];
          mem_address <= req_address[g_idx*ADDR_W +: ADDR_W];
          mem_wdata   <= req_wdata[g_idx*DATA_W +: DATA_W];
        end
        BUSY: if (mem_resp) begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

  assign req_resp  = (state == BUSY && mem_resp) ? owner_q : '0;
  assign req_rdata = mem_rdata;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-port memory arbiter that merges NUM_PORTS CPU-side request ports (instruction fetch, data, future prefetch/DMA) onto one shared downstream memory port.
- Generalises the fixed two-port (A = fetch, B = data) arrangement of the current pipeline top to any port count.
- Adds selectable round-robin or fixed-priority arbitration.
- Uses the existing hold-until-resp handshake on both sides.

Parameters:
- NUM_PORTS, 2, number of upstream request ports (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; mask width is DATA_W/8.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 highest).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_read  in  NUM_PORTS  per-port read request, held until that port's resp.
- req_write  in  NUM_PORTS  per-port write request, held until that port's resp.
- req_wmask  in  NUM_PORTS*DATA_W/8  packed byte masks; port i at [i*DATA_W/8 +: DATA_W/8].
- req_address  in  NUM_PORTS*ADDR_W  packed addresses.
- req_wdata  in  NUM_PORTS*DATA_W  packed write data.
- req_resp  out  NUM_PORTS  one-cycle completion pulse per port.
- req_rdata  out  DATA_W  read data broadcast to all ports; valid with req_resp.
- mem_read  out  1  downstream read, held until mem_resp.
- mem_write  out  1  downstream write, held until mem_resp.
- mem_wmask  out  DATA_W/8  downstream byte mask.
- mem_address  out  ADDR_W  downstream address.
- mem_wdata  out  DATA_W  downstream write data.
- mem_resp  in  1  downstream completion.
- mem_rdata  in  DATA_W  downstream read data.

Behaviour:
- Reset values:
  - state IDLE.
  - mem_read, mem_write, mem_wmask, mem_address, mem_wdata all 0.
  - req_resp all 0.
  - RR pointer 0.
- Reset mid-transaction:
  - Drops the transaction. Outputs are 0 from the cycle after rst is sampled.
  - A late mem_resp arriving in IDLE is ignored and produces no req_resp.
- FSM: IDLE, BUSY.
  - IDLE: a port is "active" if req_read or req_write is high.
  - If any port is active, select winner g. Latch g, op, address, wmask and wdata into registers. Go to BUSY next cycle.
  - BUSY: drive mem_* from the latched registers; mem_read/mem_write stay high until mem_resp.
  - When mem_resp=1 in BUSY: req_resp[g]=1 in the same cycle (combinational), req_rdata=mem_rdata, then go to IDLE next cycle.
  - Requester drops its request the cycle after resp, so it is not regranted.
- Latency: request seen in IDLE at cycle t → mem_read/mem_write high at t+1. mem_resp at cycle u → req_resp at u. Minimum occupancy is 2 cycles per transaction (IDLE, BUSY); mem_resp in the first BUSY cycle is legal.
- Round-robin (ARB_MODE=0):
  - Search starts at the RR pointer and wraps modulo NUM_PORTS.
  - On grant, pointer ← (g+1) mod NUM_PORTS; it wraps from NUM_PORTS-1 to 0.
  - Pointer is unchanged when no grant occurs.
- Fixed priority (ARB_MODE=1): lowest-index active port wins; starvation of higher indices is permitted.
- Read and write both high on one port: treated as a write, read ignored. The bench flags this as a protocol violation.
- mem_resp in IDLE: ignored.
- Request changes after grant: ignored, because fields are latched.
- req_rdata: always equals mem_rdata; meaningful only with req_resp.

Decomposition:
- Shared package mem_arb_types:
  - state enum {IDLE, BUSY}.
  - ARB_RR=0, ARB_FIXED=1 constants.
  - Op enum {OP_READ, OP_WRITE}.
- Sub-module arb_grant, parameterised by NUM_PORTS and ARB_MODE:
  - Combinational winner select plus one-hot/index output.
  - Owns the registered RR pointer, with a grant-enable input.
- Top-level mem_port_arbiter: FSM, request latches, downstream drive.

Test Plan:
1. Single read, NUM_PORTS=2: port 0 read, address 0x100. mem_resp 3 cycles after mem_read with rdata 0xDEADBEEF → mem_read rises 1 cycle after the request; mem_address=0x100; req_resp=2'b01 for 1 cycle with req_rdata=0xDEADBEEF; port 1 sees no resp.
2. RR rotation, NUM_PORTS=3, ARB_MODE=0, all three ports read continuously (re-asserting after each resp), mem_resp 1 cycle after each request → grant order 0,1,2,0,1,2; each transaction is 2 cycles.
3. Fixed priority, ARB_MODE=1, ports 0 and 1 request back-to-back → port 0 granted every time; port 1 is granted only once port 0 goes idle.
4. Write: port 1 write, address 0x2000, wdata 0x12345678, wmask 4'b0011 → mem_write=1 with exactly those values; mem_read=0; req_resp=2'b10 on mem_resp.
5. Reset during BUSY: assert rst while mem_read=1, then pulse mem_resp 2 cycles later → mem_read=0 the cycle after rst; no req_resp; RR pointer back to 0 (next simultaneous request grants port 0).
6. Same port asserts read and write at address 0x40 → mem_write=1, mem_read=0; single req_resp pulse.
